// File: rtl/pop_cat_motion.sv
// Frame-rate controller for the pop-cat sprite: diagonal bounce position plus a
// debounced button that selects the pop sheet. Outputs only move on the first blanking line.
module pop_cat_motion #(
  parameter int SCREEN_W        = 1280,
  parameter int SCREEN_H        = 720,
  parameter int SPRITE_W        = 256,
  parameter int SPRITE_H        = 256,
  parameter int STEP            = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int POP_FRAMES      = 8
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        btn_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        pop_out,
  output logic        frame_out
);

  localparam int XMAX = SCREEN_W - SPRITE_W;
  localparam int YMAX = SCREEN_H - SPRITE_H;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PC_W = (POP_FRAMES > 0) ? $clog2(POP_FRAMES + 1) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_W-1:0] POP_LOAD  = PC_W'(POP_FRAMES);
  localparam logic [11:0]     X_LIM     = 12'(XMAX);
  localparam logic [11:0]     X_STEP    = 12'(STEP);
  localparam logic [10:0]     Y_LIM     = 11'(YMAX);
  localparam logic [10:0]     Y_STEP    = 11'(STEP);
  localparam logic [9:0]      TICK_LINE = 10'(SCREEN_H);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            pending_q, pending_d;
  logic [PC_W-1:0] pop_cnt_q, pop_cnt_d;
  logic            pop_q, pop_d;
  logic [10:0]     x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            x_neg_q, x_neg_d;
  logic            y_neg_q, y_neg_d;
  logic            frame_q, frame_d;

  logic            tick;
  logic            press;
  logic [11:0]     x_wide, x_sum;
  logic [10:0]     y_wide, y_sum;
  logic [PC_W-1:0] pop_dec;

  // First pixel of the first blanking line: exactly once per frame.
  assign tick = (hcount_in == 11'd0) && (vcount_in == TICK_LINE);

  // Synchronizer, debounce and rising-edge detect of the accepted level.
  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = sync2_q;
        press = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // A press coinciding with a tick stays pending for the following tick.
  always_comb begin
    pending_d = pending_q;
    if (press) begin
      pending_d = 1'b1;
    end else if (tick) begin
      pending_d = 1'b0;
    end
  end

  // Bounce arithmetic runs one bit wider than the port so the limit test cannot wrap.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    x_neg_d = x_neg_q;
    y_neg_d = y_neg_q;
    x_wide  = {1'b0, x_q};
    y_wide  = {1'b0, y_q};
    x_sum   = x_wide + X_STEP;
    y_sum   = y_wide + Y_STEP;
    if (tick) begin
      if (!x_neg_q) begin
        if (x_sum >= X_LIM) begin
          x_d     = 11'(XMAX);
          x_neg_d = 1'b1;
        end else begin
          x_d = x_sum[10:0];
        end
      end else begin
        if (x_wide <= X_STEP) begin
          x_d     = '0;
          x_neg_d = 1'b0;
        end else begin
          x_d = 11'(x_wide - X_STEP);
        end
      end
      if (!y_neg_q) begin
        if (y_sum >= Y_LIM) begin
          y_d     = 10'(YMAX);
          y_neg_d = 1'b1;
        end else begin
          y_d = y_sum[9:0];
        end
      end else begin
        if (y_wide <= Y_STEP) begin
          y_d     = '0;
          y_neg_d = 1'b0;
        end else begin
          y_d = 10'(y_wide - Y_STEP);
        end
      end
    end
  end

  // Pop timer: a pending press (re)loads the full duration.
  always_comb begin
    pop_cnt_d = pop_cnt_q;
    pop_d     = pop_q;
    frame_d   = tick;
    pop_dec   = pop_cnt_q - 1'b1;
    if (tick) begin
      if (pending_q) begin
        pop_cnt_d = POP_LOAD;
        pop_d     = 1'b1;
      end else if (pop_cnt_q != '0) begin
        pop_cnt_d = pop_dec;
        pop_d     = (pop_dec != '0);
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      db_cnt_q  <= '0;
      pending_q <= 1'b0;
      pop_cnt_q <= '0;
      pop_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      x_neg_q   <= 1'b0;
      y_neg_q   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      pending_q <= pending_d;
      pop_cnt_q <= pop_cnt_d;
      pop_q     <= pop_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_neg_q   <= x_neg_d;
      y_neg_q   <= y_neg_d;
      frame_q   <= frame_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign pop_out   = pop_q;
  assign frame_out = frame_q;

endmodule
